onetotwo_demux_reg: RTL and testbench
=====================================

# onetotwo_demux_reg

Registered 1-to-2 demultiplexer. It steers each word of one valid/ready input stream to one of two valid/ready output streams, chosen by select `S`. It is the splitting counterpart of the team's 2:1 mux and sits where one producer feeds two consumers. Each output has a one-entry holding register and a transfer counter, so each port back-pressures independently.

## Interface
Parameters:
- `W`, default 8: data width of the input and both outputs.

Ports:
- `CLK`, input, 1: single clock. All state changes on the rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `S`, input, 1: destination select (0 → port 0, 1 → port 1). Sampled only in an accept cycle.
- `A`, input, W: input data.
- `A_VALID`, input, 1: input word present.
- `A_READY`, output, 1: block can accept `A` this cycle.
- `Y0`, output, W: port 0 data.
- `Y0_VALID`, output, 1: port 0 holds a word.
- `Y0_READY`, input, 1: port 0 consumer accepts.
- `Y1`, output, W: port 1 data.
- `Y1_VALID`, output, 1: port 1 holds a word.
- `Y1_READY`, input, 1: port 1 consumer accepts.
- `CNT0`, output, 8: count of completed port 0 transfers.
- `CNT1`, output, 8: count of completed port 1 transfers.

## Operation
- Each port n has a data register `Yn` and a flag `FULLn`, with `Yn_VALID = FULLn`.
- The input accepts when `A_VALID && A_READY`.
- Port n pops when `Yn_VALID && Yn_READY`.
- `A_READY` is combinational: `S ? (!FULL1 || Y1_READY) : (!FULL0 || Y0_READY)`. It is forced to 0 while `RST_N` is low.
- On an accept, the selected port loads `A` into `Yn` and sets `FULLn`=1. The non-selected port is untouched.
- Per-port flag update:
  - Pop without load: `FULLn` becomes 0. `Yn` keeps its last value, which is don't-care once invalid.
  - Pop and load in the same cycle: `Yn` takes the new word and `FULLn` stays 1. This is full throughput.
  - Load into an empty port: `FULLn` becomes 1.
- `Yn` must not change while `Yn_VALID`=1 and `Yn_READY`=0. Valid is never withdrawn without a pop.
- `S` has no stability requirement. Only its value in the accept cycle matters. While `A_VALID`=1 and not yet accepted, a change of `S` re-evaluates `A_READY` against the new port.
- Both ports may pop in the same cycle. A load to one port never blocks a pop on the other.
- `CNTn` increments by 1 on each port n pop and wraps from 255 to 0. It is not affected by loads.
- Per-port state is only FULL/EMPTY: EMPTY goes to FULL on load; FULL goes to EMPTY on pop without load; FULL stays FULL on pop with load.

## Timing
- Reset values, applied asynchronously on `RST_N` falling:
  - `Y0`=`Y1`=0.
  - `Y0_VALID`=`Y1_VALID`=0.
  - `CNT0`=`CNT1`=0.
  - `A_READY`=0.
- Reset is released synchronously in effect. The first accept can occur on the first rising edge with `RST_N`=1.
- Reset mid-operation drops any held word immediately. No pop is counted for dropped words.
- Latency is 1 cycle: a word accepted at edge k is presented on `Yn`/`Yn_VALID` after edge k.
- Throughput is 1 word/cycle sustained into one port while that port's `Yn_READY`=1. It is also 1 word/cycle overall when alternating ports.
- A full port with `Yn_READY`=0 stalls the input only while `S` selects that port.
- There are no combinational paths from `A` to `Yn`. The only combinational path is ready/select to `A_READY`.

## Test plan
- **Reset:** hold `RST_N`=0 with random inputs → all outputs 0, `A_READY`=0. Assert reset while `Y1_VALID`=1 → `Y1_VALID` drops without waiting for a clock edge; `CNT1` reads 0.
- **Steering:** `S`=0, `A`=8'h3C, one accept → `Y0`=8'h3C, `Y0_VALID`=1 next cycle, `Y1_VALID` stays 0. Repeat with `S`=1, `A`=8'hA5 → `Y1`=8'hA5.
- **Back-pressure:**
  - `Y0_READY`=0 and port 0 full: `S`=0 → `A_READY`=0 and `Y0` holds its value for 5 cycles.
  - Same cycle, `S`=1 → `A_READY`=1 and port 1 loads.
- **Full throughput:** `S`=0, `Y0_READY`=1, `A_VALID`=1 with data 1..10 on consecutive cycles → `Y0` shows 1..10 on consecutive cycles with no bubbles, and `CNT0`=10.
- **Simultaneous events:** port 0 full and popping while a new `S`=0 word is accepted → `Y0` updates and `Y0_VALID` stays 1. Same cycle, a port 1 pop → `CNT1` increments.
- **Counter wrap:** 256 port 1 transfers → `CNT1` goes 255→0 and `CNT0` is unchanged.

Source files
------------

// File: rtl/onetotwo_demux_reg.sv
// Registered 1-to-2 demultiplexer: one valid/ready input stream is steered by S
// into one of two independently back-pressured output ports with pop counters.
module onetotwo_demux_reg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         S,
    input  logic [W-1:0] A,
    input  logic         A_VALID,
    output logic         A_READY,
    output logic [W-1:0] Y0,
    output logic         Y0_VALID,
    input  logic         Y0_READY,
    output logic [W-1:0] Y1,
    output logic         Y1_VALID,
    input  logic         Y1_READY,
    output logic [7:0]   CNT0,
    output logic [7:0]   CNT1
);

    logic [1:0]        ready_w;
    logic [1:0]        full_w;
    logic [1:0][W-1:0] data_w;
    logic [1:0][7:0]   cnt_w;
    logic              accept_w;

    assign ready_w = {Y1_READY, Y0_READY};

    // A port can take a word if it is empty or is being drained this same cycle.
    assign A_READY  = RST_N && (S ? (!full_w[1] || ready_w[1])
                                  : (!full_w[0] || ready_w[0]));
    assign accept_w = A_VALID && A_READY;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic         sel;
            logic         load;
            logic         pop;
            logic         full_q;
            logic         full_d;
            logic [W-1:0] data_q;
            logic [W-1:0] data_d;
            logic [7:0]   cnt_q;
            logic [7:0]   cnt_d;

            if (gi == 0) begin : g_sel0
                assign sel = !S;
            end else begin : g_sel1
                assign sel = S;
            end

            assign load = accept_w && sel;
            assign pop  = full_q && ready_w[gi];

            always_comb begin
                full_d = full_q;
                data_d = data_q;
                cnt_d  = cnt_q;
                if (pop) begin
                    full_d = 1'b0;
                    cnt_d  = cnt_q + 8'd1;
                end
                // A load in the same cycle as a pop keeps the port full.
                if (load) begin
                    full_d = 1'b1;
                    data_d = A;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    full_q <= 1'b0;
                    data_q <= '0;
                    cnt_q  <= 8'd0;
                end else begin
                    full_q <= full_d;
                    data_q <= data_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign full_w[gi] = full_q;
            assign data_w[gi] = data_q;
            assign cnt_w[gi]  = cnt_q;
        end
    endgenerate

    assign Y0       = data_w[0];
    assign Y1       = data_w[1];
    assign Y0_VALID = full_w[0];
    assign Y1_VALID = full_w[1];
    assign CNT0     = cnt_w[0];
    assign CNT1     = cnt_w[1];

endmodule

// File: tb/tb_onetotwo_demux_reg.sv
// Directed bench for onetotwo_demux_reg: reset, steering, back-pressure,
// full throughput, simultaneous pop/load and counter wrap.
module tb_onetotwo_demux_reg;

    logic       CLK;
    logic       RST_N;
    logic       S;
    logic [7:0] A;
    logic       A_VALID;
    logic       A_READY;
    logic [7:0] Y0;
    logic       Y0_VALID;
    logic       Y0_READY;
    logic [7:0] Y1;
    logic       Y1_VALID;
    logic       Y1_READY;
    logic [7:0] CNT0;
    logic [7:0] CNT1;

    int checks   = 0;
    int failures = 0;

    onetotwo_demux_reg #(.W(8)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .S        (S),
        .A        (A),
        .A_VALID  (A_VALID),
        .A_READY  (A_READY),
        .Y0       (Y0),
        .Y0_VALID (Y0_VALID),
        .Y0_READY (Y0_READY),
        .Y1       (Y1),
        .Y1_VALID (Y1_VALID),
        .Y1_READY (Y1_READY),
        .CNT0     (CNT0),
        .CNT1     (CNT1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; sample 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N    = 1'b0;
        S        = 1'b0;
        A        = 8'h00;
        A_VALID  = 1'b0;
        Y0_READY = 1'b0;
        Y1_READY = 1'b0;

        // Reset held with random inputs: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            S        = 1'($urandom);
            A        = 8'($urandom);
            A_VALID  = 1'b1;
            Y0_READY = 1'($urandom);
            Y1_READY = 1'($urandom);
            #1;
            check("rst_a_ready", 32'(A_READY), 0);
            tick();
            check("rst_y0", 32'(Y0), 0);
            check("rst_y1", 32'(Y1), 0);
            check("rst_valids", 32'({Y0_VALID, Y1_VALID}), 0);
            check("rst_cnts", 32'({CNT0, CNT1}), 0);
        end
        $display("txn reset held 4 cycles");

        A_VALID  = 1'b0;
        Y0_READY = 1'b0;
        Y1_READY = 1'b0;
        S        = 1'b0;
        #3 RST_N = 1'b1;

        // Steering to port 0.
        S = 1'b0; A = 8'h3C; A_VALID = 1'b1;
        #1 check("steer0_a_ready", 32'(A_READY), 1);
        tick();
        A_VALID = 1'b0;
        check("steer0_y0", 32'(Y0), 'h3C);
        check("steer0_y0_valid", 32'(Y0_VALID), 1);
        check("steer0_y1_valid", 32'(Y1_VALID), 0);
        $display("txn S=0 A=3c -> Y0=%0h", Y0);

        // Steering to port 1.
        S = 1'b1; A = 8'hA5; A_VALID = 1'b1;
        #1 check("steer1_a_ready", 32'(A_READY), 1);
        tick();
        A_VALID = 1'b0;
        check("steer1_y1", 32'(Y1), 'hA5);
        check("steer1_y1_valid", 32'(Y1_VALID), 1);
        check("steer1_y0_hold", 32'(Y0), 'h3C);
        $display("txn S=1 A=a5 -> Y1=%0h", Y1);

        // Drain port 1 only.
        Y1_READY = 1'b1;
        tick();
        Y1_READY = 1'b0;
        check("drain1_y1_valid", 32'(Y1_VALID), 0);
        check("drain1_cnt1", 32'(CNT1), 1);
        check("drain1_cnt0", 32'(CNT0), 0);
        check("drain1_y0_valid", 32'(Y0_VALID), 1);

        // Back-pressure: port 0 full and stalled, S=0 blocks the input.
        S = 1'b0; A = 8'h77; A_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_a_ready_s0", 32'(A_READY), 0);
            tick();
            check("bp_y0_hold", 32'(Y0), 'h3C);
            check("bp_y0_valid", 32'(Y0_VALID), 1);
        end
        $display("txn port0 stalled 5 cycles, Y0=%0h", Y0);

        // Switching S to the empty port unblocks the input.
        S = 1'b1; A = 8'h5A;
        #1 check("bp_a_ready_s1", 32'(A_READY), 1);
        tick();
        A_VALID = 1'b0;
        check("bp_y1_load", 32'(Y1), 'h5A);
        check("bp_y1_valid", 32'(Y1_VALID), 1);
        check("bp_y0_still", 32'(Y0), 'h3C);

        // Both ports pop in the same cycle.
        Y0_READY = 1'b1; Y1_READY = 1'b1;
        tick();
        Y0_READY = 1'b0; Y1_READY = 1'b0;
        check("dual_pop_valids", 32'({Y0_VALID, Y1_VALID}), 0);
        check("dual_pop_cnt0", 32'(CNT0), 1);
        check("dual_pop_cnt1", 32'(CNT1), 2);

        // Reset pulse so the throughput count starts from zero.
        RST_N = 1'b0;
        #4 check("pulse_cnt0", 32'(CNT0), 0);
        RST_N = 1'b1;

        // Full throughput into port 0: words 1..10, no bubbles.
        S = 1'b0; Y0_READY = 1'b1; A_VALID = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            A = 8'(i);
            #1 check("tput_a_ready", 32'(A_READY), 1);
            tick();
            check("tput_y0", 32'(Y0), 32'(i));
            check("tput_y0_valid", 32'(Y0_VALID), 1);
        end
        A_VALID = 1'b0;
        tick();
        Y0_READY = 1'b0;
        check("tput_cnt0", 32'(CNT0), 10);
        check("tput_y0_empty", 32'(Y0_VALID), 0);
        $display("txn throughput 10 words, CNT0=%0d", CNT0);

        // Fill both ports while stalled.
        S = 1'b0; A = 8'h11; A_VALID = 1'b1;
        tick();
        S = 1'b1; A = 8'h22;
        tick();
        A_VALID = 1'b0;
        check("sim_pre_valids", 32'({Y0_VALID, Y1_VALID}), 'b11);

        // Port 0 pops and reloads while port 1 pops.
        Y0_READY = 1'b1; Y1_READY = 1'b1;
        S = 1'b0; A = 8'h33; A_VALID = 1'b1;
        #1 check("sim_a_ready", 32'(A_READY), 1);
        tick();
        A_VALID = 1'b0; Y0_READY = 1'b0; Y1_READY = 1'b0;
        check("sim_y0", 32'(Y0), 'h33);
        check("sim_y0_valid", 32'(Y0_VALID), 1);
        check("sim_y1_valid", 32'(Y1_VALID), 0);
        check("sim_cnt0", 32'(CNT0), 11);
        check("sim_cnt1", 32'(CNT1), 1);
        $display("txn simultaneous pop/load Y0=%0h CNT0=%0d CNT1=%0d", Y0, CNT0, CNT1);

        // Reset mid-operation with port 1 full: clears without a clock edge.
        S = 1'b1; A = 8'h44; A_VALID = 1'b1;
        tick();
        A_VALID = 1'b0;
        check("mid_y1_valid_pre", 32'(Y1_VALID), 1);
        #2 RST_N = 1'b0;
        #1;
        check("mid_y1_valid", 32'(Y1_VALID), 0);
        check("mid_y0_valid", 32'(Y0_VALID), 0);
        check("mid_cnt1", 32'(CNT1), 0);
        check("mid_y1", 32'(Y1), 0);
        check("mid_a_ready", 32'(A_READY), 0);
        #3 RST_N = 1'b1;
        $display("txn async reset mid-operation");

        // Counter wrap: 256 port 1 transfers, port 0 counter untouched.
        S = 1'b1; Y1_READY = 1'b1; A_VALID = 1'b1;
        for (int i = 0; i < 256; i++) begin
            A = 8'(i);
            tick();
        end
        A_VALID = 1'b0;
        check("wrap_cnt1_255", 32'(CNT1), 255);
        tick();
        Y1_READY = 1'b0;
        check("wrap_cnt1_0", 32'(CNT1), 0);
        check("wrap_cnt0", 32'(CNT0), 0);
        check("wrap_y1_last", 32'(Y1), 'hFF);
        $display("txn 256 port1 transfers, CNT1=%0d", CNT1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
